// File: rtl/speck32_pkg.sv
// Shared SPECK-32/64 definitions for the decryption datapath.
// Holds word/rotation constants, the FSM state type and the round-key slicer.
package speck32_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ALPHA      = 7;
  localparam int unsigned BETA       = 2;
  localparam int unsigned NUM_ROUNDS = 22;
  localparam int unsigned BLOCK_W    = 2 * WORD_W;
  localparam int unsigned KEYS_W     = NUM_ROUNDS * WORD_W;
  localparam int unsigned RND_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Round key i lives at bits [16i+15:16i] of the key bus.
  function automatic logic [WORD_W-1:0] key_at(input logic [KEYS_W-1:0] round_keys,
                                               input logic [RND_W-1:0]  i);
    key_at = round_keys[int'(i) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/speck32_decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle for speck32_decrypt.
//   ct_in/ct_valid/ct_ready : ciphertext word, x = [31:16], y = [15:0]
//   pt_out/pt_valid/pt_ready: plaintext word,  x = [31:16], y = [15:0]
// master = upstream/downstream environment, slave = decryption core.
interface speck32_decrypt_if;
  import speck32_pkg::*;

  logic [BLOCK_W-1:0] ct_in;
  logic               ct_valid;
  logic               ct_ready;
  logic [BLOCK_W-1:0] pt_out;
  logic               pt_valid;
  logic               pt_ready;

  modport master (
    output ct_in, ct_valid, pt_ready,
    input  ct_ready, pt_out, pt_valid
  );

  modport slave (
    input  ct_in, ct_valid, pt_ready,
    output ct_ready, pt_out, pt_valid
  );
endinterface

// File: rtl/speck32_inv_round.sv
// One combinational SPECK-32 inverse round.
//   din  : {x, y} entering the inverse round
//   key  : round key for this round
//   dout : {x', y'} with y' = ROR(x^y, 2), x' = ROL((x^k) - y', 7)
module speck32_inv_round
  import speck32_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  input  logic [WORD_W-1:0]  key,
  output logic [BLOCK_W-1:0] dout
);

  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] y;
  logic [WORD_W-1:0] xy;
  logic [WORD_W-1:0] y_n;
  logic [WORD_W-1:0] diff;

  always_comb begin
    x    = din[BLOCK_W-1:WORD_W];
    y    = din[WORD_W-1:0];
    xy   = x ^ y;
    y_n  = {xy[BETA-1:0], xy[WORD_W-1:BETA]};
    diff = (x ^ key) - y_n;
    dout = {diff[WORD_W-ALPHA-1:0], diff[WORD_W-1:WORD_W-ALPHA], y_n};
  end

endmodule

// File: rtl/speck32_decrypt.sv
// Iterative SPECK-32/64 decryption core; applies round keys ROUNDS-1 down to 0.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   round_keys     : 22 x 16-bit keys from the key-schedule generator
//   key_ready      : round_keys complete and stable
//   dec            : ciphertext / plaintext valid-ready handshakes (slave side)
// Configuration: SPECK32_DEC_UNROLL2_EN chains two inverse rounds per cycle.
module speck32_decrypt
  import speck32_pkg::*;
#(
  parameter int unsigned ROUNDS = NUM_ROUNDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [KEYS_W-1:0] round_keys,
  input  logic              key_ready,
  speck32_decrypt_if.slave  dec
);

`ifdef SPECK32_DEC_UNROLL2_EN
  localparam logic [RND_W-1:0] STEP = RND_W'(2);
`else
  localparam logic [RND_W-1:0] STEP = RND_W'(1);
`endif
  // Counter value whose round(s) finish the block.
  localparam logic [RND_W-1:0] LAST_RND = STEP - RND_W'(1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;

  logic [WORD_W-1:0]  key0;
  logic [BLOCK_W-1:0] r0_out;
  logic [BLOCK_W-1:0] round_out;

  always_comb key0 = key_at(round_keys, rnd_q);

  speck32_inv_round u_round0 (
    .din  (blk_q),
    .key  (key0),
    .dout (r0_out)
  );

`ifdef SPECK32_DEC_UNROLL2_EN
  // Second round of the pair uses key rnd-1; rnd is always odd here.
  logic [WORD_W-1:0]  key1;
  logic [BLOCK_W-1:0] r1_out;

  always_comb key1 = key_at(round_keys, rnd_q - RND_W'(1));

  speck32_inv_round u_round1 (
    .din  (r0_out),
    .key  (key1),
    .dout (r1_out)
  );

  always_comb round_out = r1_out;
`else
  always_comb round_out = r0_out;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a missing key during RUN aborts the block.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (dec.ct_valid && key_ready) state_d = RUN;
      RUN: begin
        if (!key_ready)             state_d = IDLE;
        else if (rnd_q == LAST_RND) state_d = DONE;
      end
      DONE: if (dec.pt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; ct_ready is the only input-to-output path (key_ready in IDLE).
  always_comb begin
    dec.ct_ready = reset && key_ready && (state_q == IDLE);
    dec.pt_valid = (state_q == DONE);
    dec.pt_out   = blk_q;
  end

  // Datapath next values; x/y hold their value outside load/round cycles.
  always_comb begin
    blk_d = blk_q;
    rnd_d = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (dec.ct_valid && key_ready) begin
          blk_d = dec.ct_in;
          rnd_d = RND_W'(ROUNDS - 1);
        end
      end
      RUN: begin
        if (key_ready) begin
          blk_d = round_out;
          if (rnd_q != LAST_RND) rnd_d = rnd_q - STEP;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      blk_q <= '0;
      rnd_q <= '0;
    end else begin
      blk_q <= blk_d;
      rnd_q <= rnd_d;
    end
  end

endmodule

// File: doc/speck32_decrypt.md
# speck32_decrypt

Iterative SPECK-32/64 decryption core that consumes the 22-entry round-key bus produced by the key-schedule generator. It applies the keys in reverse order, last key first. The block sits downstream of the key generator in the SPECK-32 datapath. It accepts one 32-bit ciphertext word per transaction through a valid/ready handshake and returns the 32-bit plaintext through a second valid/ready handshake.

## Interface
- ROUNDS, 22: number of rounds; must be even and ≤ 22.
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- round_keys  input  352  round key i at bits [16i+15:16i], i = 0..21; key 0 is the low word of the user key.
- key_ready  input  1  high when round_keys is complete and stable.
- ct_in  input  32  ciphertext; x = [31:16], y = [15:0].
- ct_valid  input  1  ct_in valid.
- ct_ready  output  1  block can accept ct_in.
- pt_out  output  32  plaintext; x = [31:16], y = [15:0].
- pt_valid  output  1  pt_out valid.
- pt_ready  input  1  downstream accepts pt_out.

## Operation
- Inverse round with key k, all arithmetic 16-bit modulo 2^16:
  - y' = ROR16(x ^ y, 2)
  - x' = ROL16((x ^ k) − y', 7)
- Rounds are applied with keys ROUNDS−1 down to 0.
- FSM states:
  - IDLE: ct_ready = key_ready. When ct_valid && ct_ready, load x/y from ct_in, set rnd = ROUNDS−1, go to RUN.
  - RUN: each cycle apply one inverse round with key[rnd]. If rnd == 0, go to DONE; otherwise decrement rnd.
  - DONE: pt_valid = 1 and pt_out = {x, y}. When pt_ready is high, go to IDLE.
- rnd is a 5-bit down-counter. It never wraps: the transition to DONE occurs at rnd == 0.
- If key_ready is low during RUN, abort to IDLE. No output is produced and the x/y registers keep their stale values.
- If key_ready is low during DONE, the result is still presented and held until pt_ready. Those keys were valid when used.
- ct_valid while busy is ignored, because ct_ready is low outside IDLE.
- pt_out is held stable while pt_valid is high and pt_ready is low.
- Reset (reset == 0) overrides everything, including mid-RUN and mid-DONE:
  - State goes to IDLE and rnd = 0.
  - x and y are cleared to 0.
  - Outputs: ct_ready = 0, pt_valid = 0, pt_out = 0.

## Timing
- ct_ready and pt_valid are decoded from registered state. There are no combinational paths from inputs to outputs, except that ct_ready follows key_ready in IDLE.
- Accepting at edge N gives rounds at edges N+1 … N+ROUNDS. pt_valid is high after edge N+ROUNDS, so latency is 22 cycles.
- A handshake at DONE edge M returns the block to IDLE after M. The next accept is possible at M+1.
- Throughput is one block per ROUNDS+2 cycles when pt_ready is held high.

## Configuration
- Macro: SPECK32_DEC_UNROLL2_EN.
- Defined: two inverse round instances are chained, keys rnd and rnd−1, and the block processes two rounds per cycle.
  - rnd decrements by 2.
  - DONE is entered when the pair (1, 0) completes.
  - Latency is ROUNDS/2 = 11 cycles.
- Undefined: one round per cycle, 22-cycle latency.
- The handshake and the results are identical in both modes.

## Structure
- Shared package speck32_pkg holds:
  - WORD_W = 16, ALPHA = 7, BETA = 2, NUM_ROUNDS = 22;
  - the state enum: IDLE, RUN, DONE;
  - a key-slice function key_at(round_keys, i).
- Sub-module speck32_inv_round is purely combinational: din[31:0], key[15:0], dout[31:0]. It is instantiated once, or twice under SPECK32_DEC_UNROLL2_EN.

## Test plan
- Known answer: with round keys from user key 64'h1918_1110_0908_0100, key_ready=1, ct_in=32'ha868_42f2 → pt_out=32'h6574_694c, pt_valid rising 22 cycles after accept (11 with UNROLL2).
- key_ready held 0 with ct_valid=1 → ct_ready stays 0 and no transaction occurs. Raising key_ready then accepts on the next edge.
- Back-pressure: hold pt_ready=0 for 10 cycles after pt_valid → pt_out stays constant and ct_ready stays 0. One cycle with pt_ready=1 → IDLE, then ct_ready=1.
- Abort: drop key_ready at round 10 → return to IDLE with pt_valid never asserted. A following known-answer transaction is still correct.
- Reset mid-RUN: drive reset=0 at round 5 → next cycle ct_ready=0, pt_valid=0, pt_out=0. After release, the known-answer transaction passes.
- Back-to-back: 50 random keys/plaintexts, encrypted by the reference model and then decrypted, with pt_ready=1 → every pt_out matches its plaintext, at a spacing of ROUNDS+2 cycles.
